// File: rtl/apb_mem_pkg.sv
// apb_mem_pkg
// Shared definitions for the APB memory slave:
//   WCNT_W       width of the access-phase wait counter (covers 0..15 wait states)
//   apb_phase_e  decoded bus phase (IDLE / SETUP / ACCESS)
//   lane_bits()  log2 of bytes per data word, i.e. the byte-offset bit count of PADDR
package apb_mem_pkg;

  localparam int WCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_phase_e;

  function automatic int lane_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb_mem_slave_if.sv
// apb_mem_slave_if
// APB4 completer-side signal bundle.
//   master modport: drives PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB;
//                   receives PRDATA, PREADY, PSLVERR
//   slave modport : the mirror image, used by apb_mem_slave
interface apb_mem_slave_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);

  logic                      PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [ADDR_WIDTH-1:0]     PADDR;
  logic [DATA_WIDTH-1:0]     PWDATA;
  logic [DATA_WIDTH/8-1:0]   PSTRB;
  logic [DATA_WIDTH-1:0]     PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_mem_array.sv
// apb_mem_array
// DEPTH x DATA_WIDTH word storage, no reset (contents survive PRESETn).
//   clk    write clock
//   addr   word index shared by the write and read ports
//   we     per-byte write enables, lane i covers wdata[8*i +: 8]
//   wdata  write data
//   rdata  asynchronous read of mem[addr]
module apb_mem_array #(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 6
) (
  input  logic                    clk,
  input  logic [IDX_W-1:0]        addr,
  input  logic [DATA_WIDTH/8-1:0] we,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      if (we[i]) begin
        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/apb_mem_slave.sv
// apb_mem_slave
// APB4 completer in front of a word-organised RAM with programmable wait
// states, byte strobes and PSLVERR on misaligned or out-of-range addresses.
//   PCLK     clock, all state changes on the rising edge
//   PRESETn  asynchronous active-low reset (clears the wait counter only)
//   apb      slave modport: PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB in,
//            PRDATA/PREADY/PSLVERR out (combinational, zero outside completion)
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_mem_slave_if.slave   apb
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int LSB   = lane_bits(DATA_WIDTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_WIDTH:0]   DEPTH_L    = (ADDR_WIDTH+1)'(DEPTH);
  // Byte-offset bits of PADDR; all-zero mask when words are one byte wide.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << LSB) - 1);

  apb_phase_e            phase;
  logic [WCNT_W-1:0]     wcnt;
  logic                  complete;
  logic                  addr_err;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [LANES-1:0]      wr_be;
  logic [DATA_WIDTH-1:0] rd_word;

  always_comb begin
    phase = IDLE;
    if (apb.PSEL) begin
      phase = apb.PENABLE ? ACCESS : SETUP;
    end
  end

  // Setup arms the counter; access counts it down; leaving PSEL aborts.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wcnt <= '0;
    end else begin
      case (phase)
        SETUP:   wcnt <= WCNT_W'(WAIT_STATES);
        ACCESS:  if (wcnt != '0) wcnt <= wcnt - 1'b1;
        default: wcnt <= '0;
      endcase
    end
  end

  assign word_idx = apb.PADDR >> LSB;
  assign addr_err = ({1'b0, word_idx} >= DEPTH_L) ||
                    ((apb.PADDR & ALIGN_MASK) != '0);

  // Gated by PRESETn so a reset in the completion cycle silences outputs and drops the write at once.
  assign complete = PRESETn && (phase == ACCESS) && (wcnt == '0);

  assign wr_be = (complete && apb.PWRITE && !addr_err) ? apb.PSTRB : '0;

  assign apb.PREADY  = complete;
  assign apb.PSLVERR = complete && addr_err;
  assign apb.PRDATA  = (complete && !apb.PWRITE && !addr_err) ? rd_word : '0;

  apb_mem_array #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk   (PCLK),
    .addr  (word_idx[IDX_W-1:0]),
    .we    (wr_be),
    .wdata (apb.PWDATA),
    .rdata (rd_word)
  );

endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parametrised APB4 memory-mapped slave: a word-organised RAM behind an APB completer port with configurable data width, depth and wait states, byte-lane write strobes and PSLVERR on illegal accesses. It sits on the APB segment behind the bridge/decoder, one instance per PSEL line, and is the successor to the fixed 8-bit, zero-wait, error-less slaves on that bus.

## Interface
- ADDR_WIDTH, 8, PADDR width in bits; byte address.
- DATA_WIDTH, 32, PWDATA/PRDATA width; legal values are 8, 16 and 32.
- DEPTH, 64, number of DATA_WIDTH words; must satisfy DEPTH*(DATA_WIDTH/8) <= 2**ADDR_WIDTH.
- WAIT_STATES, 0, access-phase cycles with PREADY low before completion; range 0..15.
- PCLK  in  1  clock; all state changes on the rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte-lane enables; ignored on reads.
- PRDATA  out  DATA_WIDTH  read data; valid only in the completion cycle, 0 otherwise.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response; valid only in the completion cycle, 0 otherwise.

## Operation
- Setup cycle is PSEL=1, PENABLE=0. It loads the wait counter `wcnt` with WAIT_STATES.
- Access cycle is PSEL=1, PENABLE=1. If `wcnt` != 0: PREADY=0 and `wcnt` decrements. If `wcnt` == 0: PREADY=1 and this is the completion cycle.
- Address decode:
  - Word index = PADDR >> log2(DATA_WIDTH/8).
  - Error if index >= DEPTH.
  - Error if PADDR low log2(DATA_WIDTH/8) bits are nonzero (misaligned); no misalignment check when DATA_WIDTH=8.
- Write completion, no error: on the rising edge ending the cycle, byte lane i of mem[index] is updated from PWDATA lane i where PSTRB[i]=1. PSTRB=0 is a legal no-op write that still completes.
- Read completion, no error: PRDATA = mem[index] combinationally in the completion cycle.
- Any error completion: PSLVERR=1, PRDATA=0, memory unchanged.
- Outside a completion cycle: PREADY, PSLVERR and PRDATA are all 0.
- Memory contents are not reset. They are retained across PRESETn and are undefined after power-up.
- Back-to-back transfers are allowed: a new setup cycle may immediately follow a completion cycle.

## Timing
- Reset (PRESETn=0, asynchronous): `wcnt` = 0; PREADY = 0, PSLVERR = 0, PRDATA = 0 while reset is asserted.
- Latency: completion occurs in the (WAIT_STATES+1)-th access cycle after setup. The total transfer is WAIT_STATES+2 cycles.
- PREADY, PSLVERR and PRDATA are combinational from `wcnt`, PSEL, PENABLE, PWRITE and PADDR. There is no output register.
- PSEL deasserted mid-wait (abort): `wcnt` is cleared to 0 and no write occurs. The next transfer must start with a fresh setup cycle.
- Access cycle without a preceding setup cycle (protocol violation): `wcnt` is 0, so the transfer completes immediately with normal decode. This is defined, not X.
- Inputs are sampled in the completion cycle only. Changes to PADDR/PWDATA during wait cycles take effect at completion; the master is required to hold them stable.
- Reset asserted mid-wait or in the completion cycle: the write is dropped, `wcnt` goes to 0 and outputs go to 0 immediately.

## Structure
- Package apb_mem_pkg holds:
  - the WCNT_W constant (4);
  - a function giving log2 of bytes per word;
  - an enum apb_phase_e {IDLE, SETUP, ACCESS} used for decode and coverage.
- Sub-module apb_mem_array: DEPTH x DATA_WIDTH storage with per-byte write enable and an asynchronous read port. It has no reset.
- The top level contains the phase decode, the wait counter and the error check.

## Test plan
- DATA_WIDTH=32, WAIT_STATES=0: write 0xDEADBEEF to 0x04 with PSTRB=4'hF, then read 0x04 -> PREADY high in the first access cycle, PRDATA=0xDEADBEEF, PSLVERR=0.
- Write 0x11223344 to 0x08 with PSTRB=4'b0101, after a prior value of 0xAABBCCDD -> readback 0xAA22CC44.
- WAIT_STATES=3: read 0x04 -> PREADY low for exactly 3 access cycles and high on the 4th; PRDATA is 0 until then.
- Write to 0x02 (misaligned) and to 0x100 with DEPTH=64, ADDR_WIDTH=9 (out of range) -> PSLVERR=1 with PREADY; subsequent reads show the memory unchanged.
- WAIT_STATES=2, with PSEL dropped after one wait cycle, or PRESETn pulsed low mid-wait on a write -> no write occurs, outputs are 0, and the next full transfer completes normally.
- Back-to-back write 0x04 then read 0x04 with no idle cycle between them -> the read returns the just-written data.
